// File: rtl/mux_n_reg.sv
// mux_n_reg: N-input WIDTH-bit mux feeding its own destination register,
// with illegal-select detection, a sticky error flag and a saturating error count.
module mux_n_reg #(
    parameter int              WIDTH       = 32,
    parameter int              N_INPUTS    = 5,
    parameter int              SEL_W       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              ERR_CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          selector,
    input  logic [N_INPUTS*WIDTH-1:0] Data_in,
    input  logic                      load,
    input  logic                      clear,
    output logic [WIDTH-1:0]          Data_out,
    output logic                      valid,
    output logic                      sel_err,
    output logic [SEL_W-1:0]          err_sel,
    output logic [ERR_CNT_W-1:0]      err_cnt
);
    localparam int N_SLOTS = 1 << SEL_W;

    if (N_INPUTS < 2 || N_INPUTS > 16 || N_SLOTS < N_INPUTS) begin : g_bad_params
        $error("mux_n_reg: N_INPUTS must be 2..16 and fit in SEL_W bits");
    end

    // Unused slots above N_INPUTS read as zero so the index never leaves the array.
    logic [WIDTH-1:0] in_arr [N_SLOTS];
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        if (i < N_INPUTS) begin : g_used
            assign in_arr[i] = Data_in[i*WIDTH +: WIDTH];
        end else begin : g_unused
            assign in_arr[i] = '0;
        end
    end

    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 sel_err_q, sel_err_d;
    logic [SEL_W-1:0]     err_sel_q, err_sel_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 legal, good_load, bad_load;

    always_comb begin
        legal     = 32'(selector) < N_INPUTS;
        good_load = load && legal;
        bad_load  = load && !legal;
        data_d    = clear ? RESET_VALUE : good_load ? in_arr[selector] : data_q;
        valid_d   = clear ? 1'b0 : good_load ? 1'b1 : valid_q;
        sel_err_d = clear ? 1'b0 : bad_load ? 1'b1 : sel_err_q;
        err_sel_d = clear ? '0 : bad_load ? selector : err_sel_q;
        err_cnt_d = clear ? '0 : (bad_load && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= RESET_VALUE;
            valid_q   <= 1'b0;
            sel_err_q <= 1'b0;
            err_sel_q <= '0;
            err_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
            err_sel_q <= err_sel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Data_out = data_q;
    assign valid    = valid_q;
    assign sel_err  = sel_err_q;
    assign err_sel  = err_sel_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed checks of the default 5x32 instance and a full 8x16 instance.
module tb_mux_n_reg;
    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   sel;
    logic [159:0] din;
    logic         load, clear;
    logic [31:0]  dout;
    logic         valid, sel_err;
    logic [2:0]   err_sel;
    logic [3:0]   err_cnt;

    logic [2:0]   sel2;
    logic [127:0] din2;
    logic         load2, clear2;
    logic [15:0]  dout2;
    logic         valid2, sel_err2;
    logic [2:0]   err_sel2;
    logic [3:0]   err_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_reg dut (
        .clk(clk), .reset(reset), .selector(sel), .Data_in(din), .load(load), .clear(clear),
        .Data_out(dout), .valid(valid), .sel_err(sel_err), .err_sel(err_sel), .err_cnt(err_cnt)
    );

    mux_n_reg #(.WIDTH(16), .N_INPUTS(8), .SEL_W(3)) dut8 (
        .clk(clk), .reset(reset), .selector(sel2), .Data_in(din2), .load(load2), .clear(clear2),
        .Data_out(dout2), .valid(valid2), .sel_err(sel_err2), .err_sel(err_sel2), .err_cnt(err_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; clear = 1'b0; sel = '0;
        load2 = 1'b0; clear2 = 1'b0; sel2 = '0;
        step(); step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({dout, valid, sel_err, err_sel, err_cnt} !== {32'h0, 1'b0, 1'b0, 3'd0, 4'd0}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got dout=%h v=%b se=%b es=%0d ec=%0d, want all zero", c, dout, valid, sel_err, err_sel, err_cnt);
            end
            checks++;
            if ({dout2, valid2, sel_err2, err_cnt2} !== 21'd0) begin
                errors++;
                $display("FAIL reset_hold8[%0d]: got dout=%h v=%b se=%b ec=%0d, want all zero", c, dout2, valid2, sel_err2, err_cnt2);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 5; i++) begin
            sel = 3'(i); load = 1'b1;
            step();
            checks++;
            if (dout !== 32'h1000_0000 + i || valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep[%0d]: got dout=%h v=%b, want %h v=1", i, dout, valid, 32'h1000_0000 + i);
            end
        end
        load = 1'b0; sel = 3'd0;
        step();
        checks++;
        if (dout !== 32'h1000_0004 || valid !== 1'b1) begin
            errors++;
            $display("FAIL hold: got dout=%h v=%b, want 10000004 v=1", dout, valid);
        end
    endtask

    task automatic test_illegal();
        sel = 3'd2; load = 1'b1;
        step();
        sel = 3'b110;
        step();
        checks++;
        if ({dout, valid, sel_err, err_sel, err_cnt} !== {32'h1000_0002, 1'b1, 1'b1, 3'd6, 4'd1}) begin
            errors++;
            $display("FAIL illegal: got dout=%h v=%b se=%b es=%0d ec=%0d, want 10000002 1 1 6 1", dout, valid, sel_err, err_sel, err_cnt);
        end
        sel = 3'd4;
        step();
        checks++;
        if ({dout, sel_err, err_sel, err_cnt} !== {32'h1000_0004, 1'b1, 3'd6, 4'd1}) begin
            errors++;
            $display("FAIL legal_after_illegal: got dout=%h se=%b es=%0d ec=%0d, want 10000004 1 6 1", dout, sel_err, err_sel, err_cnt);
        end
        load = 1'b0;
    endtask

    task automatic test_saturate();
        sel = 3'd7; load = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (err_cnt !== 4'((k + 1 > 15) ? 15 : k + 1) || err_sel !== 3'd7 || dout !== 32'h1000_0004) begin
                errors++;
                $display("FAIL saturate[%0d]: got ec=%0d es=%0d dout=%h, want ec=%0d es=7 dout=10000004", k, err_cnt, err_sel, dout, (k + 1 > 15) ? 15 : k + 1);
            end
        end
        clear = 1'b1; sel = 3'd1;
        step();
        checks++;
        if ({dout, valid, sel_err, err_sel, err_cnt} !== {32'h0, 1'b0, 1'b0, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL clear_over_load: got dout=%h v=%b se=%b es=%0d ec=%0d, want all zero", dout, valid, sel_err, err_sel, err_cnt);
        end
        clear = 1'b0; load = 1'b0;
    endtask

    task automatic test_async_reset();
        sel = 3'd3; load = 1'b1;
        step();
        sel = 3'd5;
        step(); step(); step();
        load = 1'b0;
        checks++;
        if ({dout, valid, sel_err, err_sel, err_cnt} !== {32'h1000_0003, 1'b1, 1'b1, 3'd5, 4'd3}) begin
            errors++;
            $display("FAIL pre_reset: got dout=%h v=%b se=%b es=%0d ec=%0d, want 10000003 1 1 5 3", dout, valid, sel_err, err_sel, err_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dout, valid, sel_err, err_sel, err_cnt} !== {32'h0, 1'b0, 1'b0, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got dout=%h v=%b se=%b es=%0d ec=%0d, want all zero", dout, valid, sel_err, err_sel, err_cnt);
        end
        step();
        reset = 1'b0;
        sel = 3'd1; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({dout, valid, sel_err, err_cnt} !== {32'h1000_0001, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL post_reset_load: got dout=%h v=%b se=%b ec=%0d, want 10000001 1 0 0", dout, valid, sel_err, err_cnt);
        end
    endtask

    task automatic test_n8();
        load2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel2 = 3'(i);
            step();
            checks++;
            if (dout2 !== 16'hA000 + 16'(i * 16'h0111) || valid2 !== 1'b1 || sel_err2 !== 1'b0 || err_cnt2 !== 4'd0) begin
                errors++;
                $display("FAIL n8_sweep[%0d]: got dout=%h v=%b se=%b ec=%0d, want %h 1 0 0", i, dout2, valid2, sel_err2, err_cnt2, 16'hA000 + 16'(i * 16'h0111));
            end
        end
        load2 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) din[i*32 +: 32] = 32'h1000_0000 + i;
        for (int i = 0; i < 8; i++) din2[i*16 +: 16] = 16'hA000 + 16'(i * 16'h0111);
        test_reset();
        test_sweep();
        test_illegal();
        test_saturate();
        test_async_reset();
        test_n8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a registered output. It is the successor of the fixed 5-way 32-bit datapath muxes.
- Adds a load enable, synchronous clear, and illegal-select detection with a sticky error flag and a saturating error counter. Replaces X-propagation on a bad select.
- Sits in the multicycle datapath wherever a source mux feeds a register (PC source, ALU-operand, write-data paths). Merges mux and destination register into one block.

Parameters:
- WIDTH, 32, data width of each input and the output
- N_INPUTS, 5, number of data inputs; legal range 2..16
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= N_INPUTS
- RESET_VALUE, 0, value loaded into Data_out on reset and on clear
- ERR_CNT_W, 4, width of the illegal-select counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- selector  in  SEL_W  input index to capture
- Data_in  in  N_INPUTS*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH]
- load  in  1  capture the selected input at the next rising edge
- clear  in  1  synchronous clear of output and status
- Data_out  out  WIDTH  registered selected data
- valid  out  1  Data_out holds data captured by a legal load since the last reset or clear
- sel_err  out  1  sticky flag: a load occurred with selector >= N_INPUTS
- err_sel  out  SEL_W  selector value of the most recent illegal load
- err_cnt  out  ERR_CNT_W  saturating count of illegal loads

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, independent of clk): Data_out=RESET_VALUE, valid=0, sel_err=0, err_sel=0, err_cnt=0.
- All other updates occur on the rising edge of clk while reset=0.
- Priority per edge: clear > load > hold.
- clear=1: Data_out=RESET_VALUE, valid=0, sel_err=0, err_sel=0, err_cnt=0. load is ignored that cycle.
- load=1, clear=0, selector < N_INPUTS:
  - Data_out = Data_in[selector*WIDTH +: WIDTH]; valid=1.
  - Error fields are unchanged.
- load=1, clear=0, selector >= N_INPUTS:
  - Data_out and valid hold.
  - sel_err=1; err_sel=selector; err_cnt increments, saturating at 2**ERR_CNT_W-1 (no wrap).
- load=0, clear=0: all outputs hold. selector and Data_in are don't-care.
- Latency: one cycle from load to the new Data_out. No combinational path from any input to any output.
- When N_INPUTS == 2**SEL_W, no select is illegal: sel_err stays 0 and err_cnt stays 0 permanently.
- Back-to-back loads capture a new value every cycle. A legal load directly after an illegal load captures normally and leaves sel_err=1.
- Reset asserted mid-sequence (any cycle) returns every output to its reset value immediately. The first legal load after reset deasserts behaves exactly as from power-up.
- Elaboration fails (generate-time error) if N_INPUTS < 2, N_INPUTS > 16, or 2**SEL_W < N_INPUTS.

Test Plan:
- Reset, then hold load=0 for 3 cycles -> Data_out=0, valid=0, sel_err=0, err_cnt=0 throughout.
- Defaults; inputs i=0..4 driven with 32'h1000_0000+i; load=1 with selector 0,1,2,3,4 on consecutive cycles -> Data_out = 32'h1000_0000, _0001, _0002, _0003, _0004 on the cycle after each load; valid=1 from the first.
- After loading input 2, load=1 with selector=3'b110 -> Data_out stays 32'h1000_0002; sel_err=1, err_sel=6, err_cnt=1. Then a legal load of selector 4 -> Data_out=32'h1000_0004, sel_err stays 1.
- 20 consecutive illegal loads with ERR_CNT_W=4 -> err_cnt reaches 15 and holds at 15. Then clear=1 with load=1 in the same cycle -> Data_out=RESET_VALUE, valid=0, all error fields 0.
- Assert reset asynchronously between clock edges while valid=1 and err_cnt=3 -> all outputs reach reset values before the next edge. Deassert, then load selector 1 -> Data_out=32'h1000_0001 one cycle later.
- N_INPUTS=8, SEL_W=3, WIDTH=16: sweep all 8 selectors -> every load legal, each input captured correctly, sel_err stays 0.
